// File: rtl/mips_control_sequencer.sv
// Multicycle control sequencer for the MIPS datapath.
// Runs fetch / decode / execute for ADDU, SB and BEQ. It drives the datapath
// load enables and selects, and it runs the MOV/MOC memory handshake. A memory
// timeout or an unsupported opcode moves it into a sticky fault state, which
// only reset clears.
module mips_control_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] state_sel,
    input  logic       alu_zero,
    input  logic       moc,
    output logic [6:0] state,
    output logic       pc_ld,
    output logic [1:0] pc_src,
    output logic       ir_ld,
    output logic       mar_ld,
    output logic       mdr_ld,
    output logic       rf_ld,
    output logic       alu_src,
    output logic [3:0] alu_op,
    output logic       mov,
    output logic       mem_rw,
    output logic       mem_byte,
    output logic       fault
);

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH_ADDR = 7'd1,
        S_FETCH_READ = 7'd2,
        S_FETCH_PC   = 7'd3,
        S_DECODE     = 7'd4,
        S_ADDU       = 7'd5,
        S_SB_ADDR    = 7'd6,
        S_SB_DATA    = 7'd7,
        S_SB_WRITE   = 7'd8,
        S_BEQ_CMP    = 7'd10,
        S_BEQ_TAKEN  = 7'd11,
        S_MEM_FAULT  = 7'd126,
        S_ILLEGAL    = 7'd127
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;

    // Counter value on the last allowed wait cycle. If moc is still low then,
    // the access has timed out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;

    assign w_timeout = (r_cnt == CNT_LAST);
    assign state     = r_state;

    // State register and wait counter, with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and next-count logic. The counter is zero in every state
    // except while a memory wait continues, so each entry into a wait state
    // starts a fresh timeout window.
    // NOTE: every comb output gets a default first, so no path leaves a value
    // unassigned (which would infer a latch).
    always_comb begin
        w_next     = S_ILLEGAL;
        w_cnt_next = '0;
        case (r_state)
            S_RESET:      w_next = S_FETCH_ADDR;
            S_FETCH_ADDR: w_next = S_FETCH_READ;
            S_FETCH_READ: begin
                if (moc) begin
                    w_next = S_FETCH_PC;
                end else if (w_timeout) begin
                    w_next = S_MEM_FAULT;
                end else begin
                    w_next     = S_FETCH_READ;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_FETCH_PC:   w_next = S_DECODE;
            S_DECODE: begin
                case (state_sel)
                    7'd5, 7'd6, 7'd10: w_next = state_t'(state_sel);
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_ADDU:       w_next = S_FETCH_ADDR;
            S_SB_ADDR:    w_next = S_SB_DATA;
            S_SB_DATA:    w_next = S_SB_WRITE;
            S_SB_WRITE: begin
                if (moc) begin
                    w_next = S_FETCH_ADDR;
                end else if (w_timeout) begin
                    w_next = S_MEM_FAULT;
                end else begin
                    w_next     = S_SB_WRITE;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_BEQ_CMP:    w_next = alu_zero ? S_BEQ_TAKEN : S_FETCH_ADDR;
            S_BEQ_TAKEN:  w_next = S_FETCH_ADDR;
            S_MEM_FAULT:  w_next = S_MEM_FAULT;
            S_ILLEGAL:    w_next = S_ILLEGAL;
            default:      w_next = S_ILLEGAL;
        endcase
    end

    // Moore output decode. The one exception is ir_ld, which is also gated by
    // moc so that IR captures the data on the cycle memory presents it.
    always_comb begin
        pc_ld    = 1'b0;
        pc_src   = PC_INC;
        ir_ld    = 1'b0;
        mar_ld   = 1'b0;
        mdr_ld   = 1'b0;
        rf_ld    = 1'b0;
        alu_src  = 1'b0;
        alu_op   = ALU_ADD;
        mov      = 1'b0;
        mem_rw   = 1'b0;
        mem_byte = 1'b0;
        fault    = 1'b0;
        case (r_state)
            S_FETCH_ADDR: mar_ld = 1'b1;
            S_FETCH_READ: begin
                mov    = 1'b1;
                mem_rw = 1'b1;
                ir_ld  = moc;
            end
            S_FETCH_PC: begin
                pc_ld  = 1'b1;
                pc_src = PC_INC;
            end
            S_ADDU: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b0;
                rf_ld   = 1'b1;
            end
            S_SB_ADDR: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                mar_ld  = 1'b1;
            end
            S_SB_DATA:    mdr_ld = 1'b1;
            S_SB_WRITE: begin
                mov      = 1'b1;
                mem_rw   = 1'b0;
                mem_byte = 1'b1;
            end
            S_BEQ_CMP: begin
                alu_op  = ALU_SUB;
                alu_src = 1'b0;
            end
            S_BEQ_TAKEN: begin
                pc_ld  = 1'b1;
                pc_src = PC_BR;
            end
            S_MEM_FAULT, S_ILLEGAL: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_control_sequencer.sv
// Testbench for mips_control_sequencer.
// The stimulus side works one instruction at a time. From the instruction kind
// and the memory response latency it builds the expected per-cycle state and
// controls, and it pushes each expected entry into a scoreboard queue. A
// separate monitor pops one entry per cycle on the falling edge and compares
// it with the DUT.
module tb_mips_control_sequencer;

    localparam int MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] state_sel;
    logic       alu_zero;
    logic       moc;
    logic [6:0] state;
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       ir_ld, mar_ld, mdr_ld, rf_ld, alu_src;
    logic [3:0] alu_op;
    logic       mov, mem_rw, mem_byte, fault;

    typedef struct packed {
        logic       pc_ld;
        logic [1:0] pc_src;
        logic       ir_ld;
        logic       mar_ld;
        logic       mdr_ld;
        logic       rf_ld;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       mov;
        logic       mem_rw;
        logic       mem_byte;
        logic       fault;
    } ctl_t;

    typedef struct {
        logic [6:0] st;
        ctl_t       ctl;
    } exp_t;

    typedef enum int {K_ADDU, K_SB, K_BEQ, K_BAD} kind_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    ctl_t dut_ctl;

    assign dut_ctl = {pc_ld, pc_src, ir_ld, mar_ld, mdr_ld, rf_ld, alu_src,
                      alu_op, mov, mem_rw, mem_byte, fault};

    mips_control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .state_sel(state_sel), .alu_zero(alu_zero),
        .moc(moc), .state(state), .pc_ld(pc_ld), .pc_src(pc_src),
        .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .rf_ld(rf_ld),
        .alu_src(alu_src), .alu_op(alu_op), .mov(mov), .mem_rw(mem_rw),
        .mem_byte(mem_byte), .fault(fault)
    );

    always #5 clk = ~clk;

    // Control word that the state table gives for each numbered state.
    function automatic ctl_t spec_ctl(input int s, input logic m);
        ctl_t c = '0;
        case (s)
            1:  c.mar_ld = 1'b1;
            2:  begin c.mov = 1'b1; c.mem_rw = 1'b1; c.ir_ld = m; end
            3:  c.pc_ld = 1'b1;
            5:  c.rf_ld = 1'b1;
            6:  begin c.alu_src = 1'b1; c.mar_ld = 1'b1; end
            7:  c.mdr_ld = 1'b1;
            8:  begin c.mov = 1'b1; c.mem_byte = 1'b1; end
            10: c.alu_op = 4'b0001;
            11: begin c.pc_ld = 1'b1; c.pc_src = 2'b01; end
            126, 127: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rsel();
        return 7'($urandom);
    endfunction

    // One clock cycle. It drives the inputs for the cycle and records what the
    // DUT must show during that cycle.
    task automatic cycle(input int exp_st, input logic rst, input logic m,
                         input logic [6:0] sel, input logic az);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        moc       = m;
        state_sel = sel;
        alu_zero  = az;
        e.st  = 7'(exp_st);
        e.ctl = spec_ctl(exp_st, m);
        sb_q.push_back(e);
    endtask

    // A cycle whose inputs the state ignores, so they are randomized.
    task automatic idle(input int st);
        cycle(st, 1'b0, rb(), rsel(), rb());
    endtask

    // Memory wait. resp = n means moc arrives on wait cycle n. Any value
    // outside 1..MEM_TIMEOUT means moc never arrives.
    task automatic mem_wait(input int st, input int resp, output bit ok);
        logic m;
        ok = 1'b0;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            m = (k == resp - 1);
            cycle(st, 1'b0, m, rsel(), rb());
            if (m) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Hold in a fault state for a while, then reset. The FSM reaches S0 at
    // the edge that samples reset, and S1 at the edge after that.
    task automatic fault_then_reset(input int st, input int hold);
        repeat (hold) idle(st);
        cycle(st, 1'b1, rb(), rsel(), rb());
        cycle(0, 1'b0, rb(), rsel(), rb());
    endtask

    task automatic run_instr(input kind_t kind, input int fresp, input int wresp,
                             input logic az, input int hold);
        bit         ok;
        logic [6:0] sel;
        idle(1);
        mem_wait(2, fresp, ok);
        if (!ok) begin
            fault_then_reset(126, hold);
            return;
        end
        idle(3);
        case (kind)
            K_ADDU: sel = 7'd5;
            K_SB:   sel = 7'd6;
            K_BEQ:  sel = 7'd10;
            default: begin
                sel = rsel();
                while (sel == 7'd5 || sel == 7'd6 || sel == 7'd10) sel = rsel();
            end
        endcase
        cycle(4, 1'b0, rb(), sel, rb());
        case (kind)
            K_ADDU: idle(5);
            K_SB: begin
                idle(6);
                idle(7);
                mem_wait(8, wresp, ok);
                if (!ok) fault_then_reset(126, hold);
            end
            K_BEQ: begin
                cycle(10, 1'b0, rb(), rsel(), az);
                if (az) idle(11);
            end
            default: fault_then_reset(127, hold);
        endcase
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state cyc%0d: got %0d exp %0d", n_cyc, state, e.st);
                end
                n_tests++;
                if (dut_ctl !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cyc%0d (state %0d): got %h exp %h",
                             n_cyc, e.st, dut_ctl, e.ctl);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        bit    ok;
        kind_t k;
        int    fr, wr;
        reset = 1'b1; moc = 1'b0; state_sel = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        cycle(0, 1'b1, 1'b1, rsel(), rb());
        cycle(0, 1'b0, 1'b1, rsel(), rb());

        // Directed programs.
        run_instr(K_ADDU, 1, 1, 1'b0, 0);
        run_instr(K_SB,   1, 1, 1'b0, 0);
        run_instr(K_BEQ,  1, 1, 1'b1, 0);
        run_instr(K_BEQ,  1, 1, 1'b0, 0);
        run_instr(K_BAD,  1, 1, 1'b0, 20);
        run_instr(K_ADDU, 0, 1, 1'b0, 2);             // fetch timeout
        run_instr(K_ADDU, MEM_TIMEOUT, 1, 1'b0, 0);   // moc on last wait cycle
        run_instr(K_SB,   1, MEM_TIMEOUT, 1'b0, 0);
        run_instr(K_SB,   2, 0, 1'b0, 3);             // write timeout

        // Reset on the third wait cycle of an SB write.
        idle(1);
        mem_wait(2, 1, ok);
        idle(3);
        cycle(4, 1'b0, rb(), 7'd6, rb());
        idle(6);
        idle(7);
        cycle(8, 1'b0, 1'b0, rsel(), rb());
        cycle(8, 1'b0, 1'b0, rsel(), rb());
        cycle(8, 1'b1, 1'b0, rsel(), rb());
        cycle(0, 1'b0, rb(), rsel(), rb());
        run_instr(K_ADDU, 0, 1, 1'b0, 1);             // full window after reset

        // Random programs.
        for (int i = 0; i < 150; i++) begin
            k  = kind_t'($urandom_range(0, 9) < 3 ? 0 : $urandom_range(0, 3));
            fr = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 4);
            wr = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 4);
            run_instr(k, fr, wr, rb(), $urandom_range(0, 4));
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending exp 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
